// File: rtl/gemac_cfg_pkg.sv
// Shared constants and types for the GEMAC configuration sequencer.
package gemac_cfg_pkg;

  localparam logic [7:0] ADR_SETTINGS  = 8'h00;
  localparam logic [7:0] ADR_UCAST_H   = 8'h04;
  localparam logic [7:0] ADR_UCAST_L   = 8'h08;
  localparam logic [7:0] ADR_MIIMODER  = 8'h14;
  localparam logic [7:0] ADR_MIIADDR   = 8'h18;
  localparam logic [7:0] ADR_MIICMD    = 8'h20;
  localparam logic [7:0] ADR_MIISTATUS = 8'h24;
  localparam logic [7:0] ADR_MIIRX     = 8'h28;

  localparam logic [4:0]  BMSR_REG     = 5'd1;
  localparam int          LINK_BIT     = 2;
  localparam logic [31:0] MIICMD_RSTAT = 32'h2;
  localparam int          MIISTAT_BUSY = 1;

  typedef enum logic [3:0] {
    ST_IDLE, ST_CFG0, ST_CFG1, ST_CFG2, ST_CFG3,
    ST_MADDR, ST_MCMD, ST_MBUSY, ST_MRD, ST_WAIT
  } state_t;

  typedef struct packed {
    logic        we;
    logic [7:0]  adr;
    logic [31:0] dat;
  } xact_t;

  function automatic logic is_cfg(input state_t s);
    return (s == ST_CFG0) || (s == ST_CFG1) || (s == ST_CFG2) || (s == ST_CFG3);
  endfunction

endpackage

// File: rtl/wb_single_master.sv
// Single-outstanding wishbone master: launches one transaction per req and
// ends it on ack or after ACK_TIMEOUT cycles without one.
module wb_single_master #(
  parameter logic [9:0] ACK_TIMEOUT = 10'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [7:0]  adr,
  input  logic [31:0] dat,
  output logic        done,
  output logic        timeout,
  output logic [31:0] rdata,
  output logic        cyc,
  output logic        stb,
  output logic        bus_we,
  output logic [7:0]  bus_adr,
  output logic [31:0] bus_wdat,
  input  logic [31:0] bus_rdat,
  input  logic        ack
);

  logic [9:0] tcnt;

  assign stb     = cyc;
  assign rdata   = bus_rdat;
  assign done    = cyc & ack;
  assign timeout = cyc & ~ack & (tcnt >= ACK_TIMEOUT - 10'd1);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc      <= 1'b0;
      bus_we   <= 1'b0;
      bus_adr  <= '0;
      bus_wdat <= '0;
      tcnt     <= '0;
    end else if (cyc) begin
      if (done || timeout) cyc <= 1'b0;
      else if (tcnt != '1) tcnt <= tcnt + 10'd1;
    end else if (req) begin
      cyc      <= 1'b1;
      bus_we   <= we;
      bus_adr  <= adr;
      bus_wdat <= dat;
      tcnt     <= '0;
    end
  end

endmodule

// File: rtl/gemac_cfg_seq.sv
// Configures the simple_gemac over wishbone after reset, then polls the PHY
// BMSR through the MIIM registers to keep link state current.
module gemac_cfg_seq
  import gemac_cfg_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR     = 48'h0050_C285_3FFF,
  parameter logic [31:0] SETTINGS_VAL = 32'h0000_0019,
  parameter logic [7:0]  MIIM_DIV     = 8'd25,
  parameter logic [4:0]  PHY_ADDR     = 5'd0,
  parameter logic [23:0] POLL_CYCLES  = 24'd500_000,
  parameter logic [9:0]  ACK_TIMEOUT  = 10'd255
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic        restart,
  input  logic        hold,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [7:0]  wb_adr,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack,
  output logic        cfg_done,
  output logic        link_up,
  output logic [15:0] phy_status,
  output logic        err
);

  state_t      state, state_nxt;
  logic [23:0] pcnt;
  logic        cfg_fail, rst_pend;
  logic        xact, req, done, timeout;
  xact_t       x;
  logic [31:0] rdata;
  wire         unused_rdata_hi = &{1'b0, rdata[31:16]};

  wb_single_master #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_master (
    .clk(wb_clk), .rst_n(wb_rst_n),
    .req(req), .we(x.we), .adr(x.adr), .dat(x.dat),
    .done(done), .timeout(timeout), .rdata(rdata),
    .cyc(wb_cyc), .stb(wb_stb), .bus_we(wb_we), .bus_adr(wb_adr),
    .bus_wdat(wb_dat_o), .bus_rdat(wb_dat_i), .ack(wb_ack)
  );

  // NOTE: always_comb assigns every output a default first so no path infers a latch.
  always_comb begin
    xact = 1'b1;
    x    = '{we: 1'b1, adr: ADR_SETTINGS, dat: 32'h0};
    case (state)
      ST_CFG0:  x = '{we: 1'b1, adr: ADR_SETTINGS,  dat: SETTINGS_VAL};
      ST_CFG1:  x = '{we: 1'b1, adr: ADR_UCAST_H,   dat: {16'h0, MAC_ADDR[47:32]}};
      ST_CFG2:  x = '{we: 1'b1, adr: ADR_UCAST_L,   dat: MAC_ADDR[31:0]};
      ST_CFG3:  x = '{we: 1'b1, adr: ADR_MIIMODER,  dat: {24'h0, MIIM_DIV}};
      ST_MADDR: x = '{we: 1'b1, adr: ADR_MIIADDR,   dat: {19'h0, BMSR_REG, 3'b0, PHY_ADDR}};
      ST_MCMD:  x = '{we: 1'b1, adr: ADR_MIICMD,    dat: MIICMD_RSTAT};
      ST_MBUSY: x = '{we: 1'b0, adr: ADR_MIISTATUS, dat: 32'h0};
      ST_MRD:   x = '{we: 1'b0, adr: ADR_MIIRX,     dat: 32'h0};
      default:  xact = 1'b0;
    endcase
  end

  // hold and restart only gate the launch; an in-flight transaction always finishes.
  assign req = xact & ~wb_cyc & ~hold & ~restart;

  always_comb begin
    state_nxt = state;
    if (wb_cyc) begin
      if (done || timeout) begin
        if (restart || rst_pend) state_nxt = ST_CFG0;
        else if (timeout)        state_nxt = ST_WAIT;
        else begin
          case (state)
            ST_CFG0:  state_nxt = ST_CFG1;
            ST_CFG1:  state_nxt = ST_CFG2;
            ST_CFG2:  state_nxt = ST_CFG3;
            ST_CFG3:  state_nxt = ST_MADDR;
            ST_MADDR: state_nxt = ST_MCMD;
            ST_MCMD:  state_nxt = ST_MBUSY;
            ST_MBUSY: state_nxt = rdata[MIISTAT_BUSY] ? ST_MBUSY : ST_MRD;
            ST_MRD:   state_nxt = ST_WAIT;
            default:  state_nxt = state;
          endcase
        end
      end
    end else if (restart) begin
      state_nxt = ST_CFG0;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_CFG0;
        ST_WAIT: if (pcnt >= POLL_CYCLES - 24'd1) state_nxt = cfg_fail ? ST_CFG0 : ST_MADDR;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state      <= ST_IDLE;
      pcnt       <= '0;
      cfg_fail   <= 1'b0;
      rst_pend   <= 1'b0;
      cfg_done   <= 1'b0;
      link_up    <= 1'b0;
      phy_status <= '0;
      err        <= 1'b0;
    end else begin
      state    <= state_nxt;
      rst_pend <= wb_cyc & ~(done | timeout) & (rst_pend | restart);

      if (state != ST_WAIT) pcnt <= '0;
      else if (pcnt != '1)  pcnt <= pcnt + 24'd1;

      // Remembers whether the wait was entered from a failed configuration write.
      if (wb_cyc && (done || timeout)) cfg_fail <= timeout & is_cfg(state);

      if (timeout)      err <= 1'b1;
      else if (restart) err <= 1'b0;

      if (restart)                      cfg_done <= 1'b0;
      else if (done && state == ST_CFG3) cfg_done <= 1'b1;

      if (done && state == ST_MRD) begin
        phy_status <= rdata[15:0];
        link_up    <= rdata[LINK_BIT];
      end
    end
  end

endmodule

// File: tb/tb_gemac_cfg_seq.sv
// Scoreboard bench: stimulus queues expected transactions, a monitor checks
// each one as cyc rises, and a behavioural slave supplies acks and read data.
module tb_gemac_cfg_seq;
  import gemac_cfg_pkg::*;

  localparam logic [23:0] POLL = 24'd100;
  localparam logic [9:0]  ATO  = 10'd15;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n = 1'b0;
  logic        restart = 1'b0, hold = 1'b0;
  logic        wb_cyc, wb_stb, wb_we;
  logic [7:0]  wb_adr;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack = 1'b0;
  logic        cfg_done, link_up, err;
  logic [15:0] phy_status;

  gemac_cfg_seq #(.POLL_CYCLES(POLL), .ACK_TIMEOUT(ATO)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .restart(restart), .hold(hold),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack),
    .cfg_done(cfg_done), .link_up(link_up), .phy_status(phy_status), .err(err)
  );

  always #5 wb_clk = ~wb_clk;

  int n_checks = 0, n_err = 0, n_xact = 0;
  xact_t exp_q[$];
  xact_t mon_e;
  logic  sb_on = 1'b0, cyc_prev = 1'b0;

  // Slave configuration, set by the stimulus.
  int         ack_lat = 1, stall_lat = 1, busy_cfg = 0;
  logic [7:0] stall_adr = 8'hFF, no_ack_adr = 8'hFF;
  logic [15:0] rx_val = '0;
  int         hi_cnt = 0, busy_seen = 0, lat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic w, input logic [7:0] a, input logic [31:0] d);
    xact_t e;
    e.we = w; e.adr = a; e.dat = d;
    exp_q.push_back(e);
  endtask

  task automatic push_cfg();
    push(1'b1, 8'h00, 32'h0000_0019);
    push(1'b1, 8'h04, 32'h0000_0050);
    push(1'b1, 8'h08, 32'hC285_3FFF);
    push(1'b1, 8'h14, 32'h0000_0019);
  endtask

  task automatic push_poll_start();
    push(1'b1, 8'h18, 32'h0000_0100);
    push(1'b1, 8'h20, 32'h0000_0002);
  endtask

  task automatic wait_start(input logic [7:0] adr, input int budget, input string name);
    int n = 0;
    @(negedge wb_clk);
    while (!(wb_cyc && wb_adr == adr) && n < budget) begin
      @(negedge wb_clk);
      n++;
    end
    check({name, "_start_seen"}, {31'b0, n < budget}, 32'd1);
  endtask

  task automatic wait_ack(input logic [7:0] adr, input int budget, input string name);
    int n = 0;
    @(negedge wb_clk);
    while (!(wb_cyc && wb_ack && wb_adr == adr) && n < budget) begin
      @(negedge wb_clk);
      n++;
    end
    check({name, "_ack_seen"}, {31'b0, n < budget}, 32'd1);
  endtask

  task automatic enter_reset();
    @(negedge wb_clk);
    sb_on = 1'b0;
    wb_rst_n = 1'b0;
    exp_q.delete();
    @(negedge wb_clk);
  endtask

  task automatic release_reset();
    sb_on = 1'b1;
    wb_rst_n = 1'b1;
  endtask

  // Slave: acks after a per-address latency, returns busy for busy_cfg status reads.
  always @(posedge wb_clk) begin
    #1;
    if (!wb_rst_n) busy_seen = 0;
    if (!wb_cyc) begin
      hi_cnt = 0;
      wb_ack = 1'b0;
    end else begin
      hi_cnt++;
      lat = (wb_adr == stall_adr) ? stall_lat : ack_lat;
      if (wb_adr != no_ack_adr && hi_cnt >= lat && !wb_ack) begin
        wb_ack = 1'b1;
        if (wb_adr == 8'h24) begin
          wb_dat_i = (busy_seen < busy_cfg) ? 32'h2 : 32'h0;
          busy_seen++;
        end else if (wb_adr == 8'h28) wb_dat_i = {16'h0, rx_val};
        else wb_dat_i = 32'hDEAD_BEEF;
      end else wb_ack = 1'b0;
    end
  end

  always @(negedge wb_clk) begin
    if (sb_on) begin
      check("stb_eq_cyc", {31'b0, wb_stb}, {31'b0, wb_cyc});
      if (wb_cyc && !cyc_prev) begin
        n_xact++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL sb_extra: got adr %h we %b, expected no transaction", wb_adr, wb_we);
        end else begin
          mon_e = exp_q.pop_front();
          check($sformatf("xact%0d_we", n_xact), {31'b0, wb_we}, {31'b0, mon_e.we});
          check($sformatf("xact%0d_adr", n_xact), {24'b0, wb_adr}, {24'b0, mon_e.adr});
          if (mon_e.we) check($sformatf("xact%0d_dat", n_xact), wb_dat_o, mon_e.dat);
        end
      end
    end
    cyc_prev = wb_cyc;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int gap, hi, cyc_seen;

    // Reset state.
    repeat (3) @(negedge wb_clk);
    check("rst_cyc", {31'b0, wb_cyc}, 0);
    check("rst_stb", {31'b0, wb_stb}, 0);
    check("rst_we", {31'b0, wb_we}, 0);
    check("rst_adr", {24'b0, wb_adr}, 0);
    check("rst_dat", wb_dat_o, 0);
    check("rst_cfg_done", {31'b0, cfg_done}, 0);
    check("rst_link_up", {31'b0, link_up}, 0);
    check("rst_phy_status", {16'b0, phy_status}, 0);
    check("rst_err", {31'b0, err}, 0);

    // Full configuration, three busy status reads, then a gap to the next poll.
    busy_cfg = 3; rx_val = 16'h796D;
    push_cfg(); push_poll_start();
    repeat (4) push(1'b0, 8'h24, 32'h0);
    push(1'b0, 8'h28, 32'h0);
    push(1'b1, 8'h18, 32'h0000_0100);
    release_reset();
    wait_ack(8'h14, 200, "t2_miimoder");
    check("t2_cfg_done_before", {31'b0, cfg_done}, 0);
    @(negedge wb_clk);
    check("t2_cfg_done_after", {31'b0, cfg_done}, 1);
    wait_ack(8'h28, 500, "t2_miirx");
    @(negedge wb_clk);
    check("t2_phy_status", {16'b0, phy_status}, 32'h796D);
    check("t2_link_up", {31'b0, link_up}, 1);
    gap = 0;
    while (!wb_cyc && gap < 1000) begin
      gap++;
      @(negedge wb_clk);
    end
    // POLL wait cycles plus the one launch cycle of the MADDR write.
    check("t2_poll_gap", gap, POLL + 1);
    @(negedge wb_clk);
    check("t2_queue_empty", exp_q.size(), 0);

    // Slave never acks the UCAST_H write.
    enter_reset();
    busy_cfg = 0; no_ack_adr = 8'h04;
    push(1'b1, 8'h00, 32'h0000_0019);
    push(1'b1, 8'h04, 32'h0000_0050);
    push(1'b1, 8'h00, 32'h0000_0019);
    release_reset();
    wait_start(8'h04, 50, "t3_ucast_h");
    hi = 0;
    while (wb_cyc && hi < 100) begin
      hi++;
      @(negedge wb_clk);
    end
    check("t3_cyc_high_cycles", hi, ATO);
    check("t3_err", {31'b0, err}, 1);
    check("t3_cfg_done", {31'b0, cfg_done}, 0);
    wait_start(8'h00, 300, "t3_retry");
    @(negedge wb_clk);
    check("t3_queue_empty", exp_q.size(), 0);
    check("t3_err_sticky", {31'b0, err}, 1);
    check("t3_cfg_done_retry", {31'b0, cfg_done}, 0);
    no_ack_adr = 8'hFF;

    // hold across the end of WAIT.
    enter_reset();
    rx_val = 16'h7809;
    push_cfg(); push_poll_start();
    push(1'b0, 8'h24, 32'h0);
    push(1'b0, 8'h28, 32'h0);
    push(1'b1, 8'h18, 32'h0000_0100);
    release_reset();
    wait_ack(8'h28, 300, "t4_miirx");
    @(negedge wb_clk);
    hold = 1'b1;
    check("t4_link_up", {31'b0, link_up}, 0);
    check("t4_phy_status", {16'b0, phy_status}, 32'h7809);
    cyc_seen = 0;
    repeat (300) begin
      @(negedge wb_clk);
      if (wb_cyc) cyc_seen++;
    end
    check("t4_cyc_during_hold", cyc_seen, 0);
    hold = 1'b0;
    @(negedge wb_clk);
    check("t4_cyc_after_hold", {31'b0, wb_cyc}, 1);
    @(negedge wb_clk);
    check("t4_queue_empty", exp_q.size(), 0);

    // restart while the status read is stalled.
    enter_reset();
    stall_adr = 8'h24; stall_lat = 5;
    push_cfg(); push_poll_start();
    push(1'b0, 8'h24, 32'h0);
    push(1'b1, 8'h00, 32'h0000_0019);
    release_reset();
    wait_start(8'h24, 300, "t5_status");
    check("t5_cfg_done_before", {31'b0, cfg_done}, 1);
    @(negedge wb_clk);
    restart = 1'b1;
    @(negedge wb_clk);
    restart = 1'b0;
    check("t5_cfg_done_cleared", {31'b0, cfg_done}, 0);
    check("t5_err_cleared", {31'b0, err}, 0);
    check("t5_read_in_flight", {31'b0, wb_cyc}, 1);
    wait_ack(8'h24, 20, "t5_status");
    wait_start(8'h00, 20, "t5_settings");
    @(negedge wb_clk);
    check("t5_queue_empty", exp_q.size(), 0);
    check("t5_cfg_done_low", {31'b0, cfg_done}, 0);
    stall_adr = 8'hFF;

    // Reset asserted in the middle of the second poll's MADDR write.
    enter_reset();
    rx_val = 16'h796D;
    push_cfg(); push_poll_start();
    push(1'b0, 8'h24, 32'h0);
    push(1'b0, 8'h28, 32'h0);
    push(1'b1, 8'h18, 32'h0000_0100);
    release_reset();
    wait_ack(8'h28, 300, "t6_miirx");
    @(negedge wb_clk);
    check("t6_link_up_before", {31'b0, link_up}, 1);
    ack_lat = 4;
    wait_start(8'h18, 300, "t6_maddr");
    @(negedge wb_clk);
    check("t6_queue_empty_mid", exp_q.size(), 0);
    check("t6_cfg_done_before", {31'b0, cfg_done}, 1);
    #2 wb_rst_n = 1'b0;
    #1;
    check("t6_rst_cyc", {31'b0, wb_cyc}, 0);
    check("t6_rst_stb", {31'b0, wb_stb}, 0);
    check("t6_rst_cfg_done", {31'b0, cfg_done}, 0);
    check("t6_rst_link_up", {31'b0, link_up}, 0);
    exp_q.delete();
    push(1'b1, 8'h00, 32'h0000_0019);
    push(1'b1, 8'h04, 32'h0000_0050);
    ack_lat = 1;
    @(negedge wb_clk);
    @(negedge wb_clk);
    wb_rst_n = 1'b1;
    wait_start(8'h04, 50, "t6_restart_seq");
    @(negedge wb_clk);
    check("t6_queue_empty", exp_q.size(), 0);
    sb_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
